// File: rtl/eth_phy_rx_block_aligner.sv
// eth_phy_rx_block_aligner: 64b/66b-style block lock FSM with internal barrel-shift or external SERDES bit-slip.
module eth_phy_rx_block_aligner #(
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2,
    parameter int FRAME_WIDTH  = DATA_WIDTH + HDR_WIDTH,
    parameter int SH_CNT_MAX   = 64,
    parameter int INVALID_MAX  = 16,
    parameter int SLIP_WAIT    = 2,
    parameter int BITSLIP_MODE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FRAME_WIDTH-1:0]         i_serdes_rx,
    input  logic                           i_serdes_rx_valid,
    output logic [DATA_WIDTH-1:0]          o_serdes_rx_data,
    output logic [HDR_WIDTH-1:0]           o_serdes_rx_hdr,
    output logic                           o_serdes_rx_valid,
    output logic                           o_serdes_rx_bitslip,
    output logic                           o_rx_block_lock,
    output logic [$clog2(FRAME_WIDTH)-1:0] o_sh_pos,
    output logic [15:0]                    o_slip_count
);
    localparam int PW = $clog2(FRAME_WIDTH);
    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int WW = $clog2(SLIP_WAIT + 2);

    // Registered states are LOCK_INIT/TEST_SH/SLIP/SLIP_WAIT; the rest name the per-word test outcome.
    typedef enum logic [2:0] {
        ST_LOCK_INIT, ST_RESET_CNT, ST_TEST_SH, ST_VALID_SH,
        ST_INVALID_SH, ST_GOOD_64, ST_SLIP, ST_SLIP_WAIT
    } state_t;

    state_t                 r_state, w_state_nxt, w_test;
    logic [FRAME_WIDTH-1:0] r_prev, w_window;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [HDR_WIDTH-1:0]   r_hdr, w_hdr;
    logic                   r_valid, r_bitslip, r_lock, w_sh_valid, w_done;
    logic [PW-1:0]          r_sh_pos, w_sh_pos_nxt;
    logic [15:0]            r_slip_cnt;
    logic [CW-1:0]          r_sh_cnt, r_inv_cnt, w_cnt_inc, w_inv_inc;
    logic [WW-1:0]          r_wait;

    assign w_window   = FRAME_WIDTH'({i_serdes_rx, r_prev} >> r_sh_pos);
    assign w_hdr      = w_window[HDR_WIDTH-1:0];
    assign w_sh_valid = w_hdr[0] ^ w_hdr[1];
    assign w_cnt_inc  = r_sh_cnt + 1'b1;
    assign w_inv_inc  = r_inv_cnt + CW'(!w_sh_valid);
    assign w_done     = w_cnt_inc == CW'(SH_CNT_MAX);
    // External slip mode leaves the window at offset 0; the SERDES moves the bits instead.
    assign w_sh_pos_nxt = (BITSLIP_MODE != 0 || r_sh_pos == PW'(FRAME_WIDTH - 1)) ? '0 : r_sh_pos + 1'b1;

    always_comb begin
        w_test = ST_TEST_SH;
        if (!w_sh_valid && (w_inv_inc == CW'(INVALID_MAX) || !r_lock))
            w_test = ST_SLIP;
        else if (w_done)
            w_test = (w_inv_inc == '0) ? ST_GOOD_64 : ST_RESET_CNT;
        else
            w_test = w_sh_valid ? ST_VALID_SH : ST_INVALID_SH;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOCK_INIT: w_state_nxt = i_serdes_rx_valid ? ST_TEST_SH : ST_LOCK_INIT;
            ST_TEST_SH:   w_state_nxt = (i_serdes_rx_valid && w_test == ST_SLIP) ? ST_SLIP : ST_TEST_SH;
            ST_SLIP:      w_state_nxt = (SLIP_WAIT == 0) ? ST_TEST_SH : ST_SLIP_WAIT;
            ST_SLIP_WAIT: w_state_nxt = (i_serdes_rx_valid && r_wait == WW'(SLIP_WAIT - 1)) ? ST_TEST_SH : ST_SLIP_WAIT;
            default:      w_state_nxt = ST_LOCK_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LOCK_INIT;
            r_prev     <= '0;
            r_data     <= '0;
            r_hdr      <= '0;
            r_valid    <= 1'b0;
            r_bitslip  <= 1'b0;
            r_lock     <= 1'b0;
            r_sh_pos   <= '0;
            r_slip_cnt <= '0;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_wait     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= i_serdes_rx_valid;
            r_bitslip <= 1'b0;
            if (i_serdes_rx_valid) begin
                r_prev <= i_serdes_rx;
                r_data <= w_window[FRAME_WIDTH-1:HDR_WIDTH];
                r_hdr  <= w_hdr;
            end
            if (r_state != ST_SLIP_WAIT)
                r_wait <= '0;
            else if (i_serdes_rx_valid)
                r_wait <= r_wait + 1'b1;
            if (i_serdes_rx_valid && r_state == ST_TEST_SH) begin
                r_sh_cnt  <= (w_test == ST_VALID_SH || w_test == ST_INVALID_SH) ? w_cnt_inc : '0;
                r_inv_cnt <= (w_test == ST_VALID_SH || w_test == ST_INVALID_SH) ? w_inv_inc : '0;
                if (w_test == ST_GOOD_64)
                    r_lock <= 1'b1;
                if (w_test == ST_SLIP) begin
                    r_lock     <= 1'b0;
                    r_bitslip  <= 1'b1;
                    r_sh_pos   <= w_sh_pos_nxt;
                    r_slip_cnt <= r_slip_cnt + {15'd0, r_slip_cnt != 16'hFFFF};
                end
            end
        end
    end

    assign o_serdes_rx_data    = r_data;
    assign o_serdes_rx_hdr     = r_hdr;
    assign o_serdes_rx_valid   = r_valid;
    assign o_serdes_rx_bitslip = r_bitslip;
    assign o_rx_block_lock     = r_lock;
    assign o_sh_pos            = r_sh_pos;
    assign o_slip_count        = r_slip_cnt;
endmodule

// File: tb/tb_eth_phy_rx_block_aligner.sv
// tb_eth_phy_rx_block_aligner: vector table plus scoreboarded block streams at chosen bit offsets.
module tb_eth_phy_rx_block_aligner;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [65:0] rx = '0;
    logic        v = 1'b0;
    logic [63:0] o_data, o_data1;
    logic [1:0]  o_hdr, o_hdr1;
    logic        o_valid, o_valid1, o_bs, o_bs1, o_lock, o_lock1;
    logic [6:0]  o_pos, o_pos1;
    logic [15:0] o_slip, o_slip1;

    eth_phy_rx_block_aligner dut (
        .clk(clk), .rst(rst), .i_serdes_rx(rx), .i_serdes_rx_valid(v),
        .o_serdes_rx_data(o_data), .o_serdes_rx_hdr(o_hdr), .o_serdes_rx_valid(o_valid),
        .o_serdes_rx_bitslip(o_bs), .o_rx_block_lock(o_lock), .o_sh_pos(o_pos),
        .o_slip_count(o_slip)
    );

    eth_phy_rx_block_aligner #(.BITSLIP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i_serdes_rx(rx), .i_serdes_rx_valid(v),
        .o_serdes_rx_data(o_data1), .o_serdes_rx_hdr(o_hdr1), .o_serdes_rx_valid(o_valid1),
        .o_serdes_rx_bitslip(o_bs1), .o_rx_block_lock(o_lock1), .o_sh_pos(o_pos1),
        .o_slip_count(o_slip1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [65:0] w;
        bit          ev;
        logic [65:0] ew;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [65:0] q[$];
    logic [65:0] prev_b = '0;
    int          k = 0;
    bit          sb_on = 0;
    int          pulses = 0;
    int          pulses1 = 0;
    bit          bs_prev = 0;
    bit          pos1_nz = 0;
    vec_t        tv[8];

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] make_block(input bit bad);
        logic [65:0] b;
        b[65:2] = {$urandom, $urandom};
        b[1:0]  = bad ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
        return b;
    endfunction

    // Word j carries block j starting at bit k, with the tail of block j-1 below it.
    task automatic step(input bit val, input bit bad);
        logic [65:0]  b;
        logic [131:0] c;
        v = val;
        if (val) begin
            b  = make_block(bad);
            c  = {b, prev_b};
            rx = 66'(c >> (66 - k));
            if (sb_on) q.push_back(prev_b);
            prev_b = b;
        end
        @(posedge clk);
        #1;
        chk("valid_mirror", 66'(o_valid), 66'(val));
        if (o_valid && q.size() > 0) chk("out_block", {o_data, o_hdr}, q.pop_front());
        chk("bitslip_width", 66'(o_bs & bs_prev), 66'(0));
        bs_prev = o_bs;
        if (o_bs) pulses++;
        if (o_bs1) pulses1++;
        if (o_pos1 != 0) pos1_nz = 1;
    endtask

    task automatic do_reset(input bit val);
        rst = 1'b1;
        v   = val;
        rx  = {$urandom, $urandom, 2'b01};
        @(posedge clk);
        #1;
        rst = 1'b0;
        v   = 1'b0;
        prev_b = '0;
        q.delete();
        bs_prev = 0;
        pulses = 0;
        pulses1 = 0;
        pos1_nz = 0;
        chk("rst_lock", 66'(o_lock), 66'(0));
        chk("rst_pos", 66'(o_pos), 66'(0));
        chk("rst_slip_count", 66'(o_slip), 66'(0));
        chk("rst_valid", 66'(o_valid), 66'(0));
        chk("rst_bitslip", 66'(o_bs), 66'(0));
        chk("rst_out", {o_data, o_hdr}, 66'(0));
        chk("rst_lock_ext", 66'(o_lock1), 66'(0));
        chk("rst_slip_count_ext", 66'(o_slip1), 66'(0));
    endtask

    initial begin
        logic [65:0] a, b, c, d, e;
        int acc;
        bit val;
        a = {64'h0123456789abcdef, 2'b01};
        b = {64'hfedcba9876543210, 2'b10};
        c = {64'hdeadbeefcafef00d, 2'b01};
        d = {64'h5555aaaa3333cccc, 2'b10};
        e = {64'h0000000000000000, 2'b01};
        tv[0] = '{1, a, 1, 66'(0)};
        tv[1] = '{0, e, 0, 66'(0)};
        tv[2] = '{1, b, 1, a};
        tv[3] = '{1, c, 1, b};
        tv[4] = '{0, d, 0, b};
        tv[5] = '{0, e, 0, b};
        tv[6] = '{1, d, 1, c};
        tv[7] = '{1, e, 1, d};

        do_reset(0);
        foreach (tv[i]) begin
            v  = tv[i].v;
            rx = tv[i].w;
            @(posedge clk);
            #1;
            chk("tbl_valid", 66'(o_valid), 66'(tv[i].ev));
            chk("tbl_block", {o_data, o_hdr}, tv[i].ew);
        end

        // Aligned stream: lock, 15 invalid in one window, then 16 invalid forcing a slip.
        do_reset(0);
        k = 0;
        sb_on = 1;
        for (int i = 1; i <= 145; i++) begin
            step(1, (i >= 65 && i <= 79) || (i >= 129 && i <= 144));
            if (i == 64) chk("lock_before_65", 66'(o_lock), 66'(0));
            if (i == 65) chk("lock_at_65", 66'(o_lock), 66'(1));
            if (i == 65) chk("lock_at_65_ext", 66'(o_lock1), 66'(1));
            if (i > 65 && i < 145) chk("lock_held", 66'(o_lock), 66'(1));
            if (i == 144) chk("no_slips_yet", 66'(pulses), 66'(0));
            if (i == 144) chk("slip_count_0", 66'(o_slip), 66'(0));
        end
        chk("lock_drop_16", 66'(o_lock), 66'(0));
        chk("slip_pulse_16", 66'(o_bs), 66'(1));
        chk("pos_after_slip", 66'(o_pos), 66'(1));
        chk("slip_count_1", 66'(o_slip), 66'(1));
        chk("ext_pos_after_slip", 66'(o_pos1), 66'(0));
        chk("ext_slip_pulse", 66'(o_bs1), 66'(1));

        // Window walks all remaining offsets and wraps 65 -> 0 before relocking.
        sb_on = 0;
        for (int n = 0; n < 4000 && !o_lock; n++) step(1, 0);
        chk("wrap_lock", 66'(o_lock), 66'(1));
        chk("wrap_pos", 66'(o_pos), 66'(0));
        chk("wrap_slip_count", 66'(o_slip), 66'(66));
        chk("wrap_pulses", 66'(pulses), 66'(66));
        sb_on = 1;
        for (int n = 0; n < 10; n++) step(1, 0);
        do_reset(1);

        // 17-bit misalignment: internal mode realigns, external mode only pulses.
        k = 17;
        sb_on = 0;
        for (int n = 0; n < 4000 && !o_lock; n++) step(1, 0);
        chk("mis17_lock", 66'(o_lock), 66'(1));
        chk("mis17_pos", 66'(o_pos), 66'(17));
        chk("mis17_slip_count", 66'(o_slip), 66'(17));
        chk("mis17_pulses", 66'(pulses), 66'(17));
        sb_on = 1;
        for (int n = 0; n < 20; n++) begin
            step(1, 0);
            chk("mis17_hdr_valid", 66'(o_hdr[0] ^ o_hdr[1]), 66'(1));
        end
        chk("ext_pos_fixed", 66'(pos1_nz), 66'(0));
        chk("ext_pulsed", 66'(pulses1 > 0), 66'(1));
        chk("ext_slip_count", 66'(o_slip1), 66'(pulses1));
        chk("ext_no_lock", 66'(o_lock1), 66'(0));

        // 50% valid gaps: lock still follows the 65th accepted word.
        do_reset(0);
        k = 0;
        sb_on = 1;
        acc = 0;
        for (int n = 0; n < 2000 && acc < 65; n++) begin
            val = 1'($urandom_range(0, 1));
            step(val, 0);
            if (val) acc++;
            if (val && acc == 64) chk("gap_lock_64", 66'(o_lock), 66'(0));
            if (val && acc == 65) chk("gap_lock_65", 66'(o_lock), 66'(1));
        end
        chk("gap_accepted", 66'(acc), 66'(65));
        chk("gap_no_slips", 66'(pulses), 66'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
